// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port, packed read ports and status flags of the multi-port register file.
interface regfile_mp_if #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 3,
    parameter int NREAD   = 2
);
    logic                     regwrite;
    logic [REGBITS-1:0]       wa;
    logic [WIDTH-1:0]         wd;
    logic [NREAD*REGBITS-1:0] ra;
    logic [NREAD*WIDTH-1:0]   rd;
    logic                     busy;
    logic                     wr_dropped;
    modport master (output regwrite, wa, wd, ra, input rd, busy, wr_dropped);
    modport slave (input regwrite, wa, wd, ra, output rd, busy, wr_dropped);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2**REGBITS x WIDTH register file, NREAD async reads, entry 0 reads zero, clear sweep after reset.
// Define REGFILE_BYPASS_EN to forward the write data to read ports addressing wa in the same cycle.
module regfile_mp #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 3,
    parameter int NREAD   = 2
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** REGBITS;
    typedef enum logic {CLEAR, READY} state_t;
    state_t             state, state_n;
    logic [REGBITS-1:0] ptr, ptr_n;
    logic               busy_q, busy_n, dropped_q, dropped_n;
    logic               clearing, mem_we;
    logic [REGBITS-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_wd;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [WIDTH-1:0]   rd_p [NREAD];
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            ptr       <= REGBITS'(1);
            busy_q    <= 1'b1;
            dropped_q <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            busy_q    <= busy_n;
            dropped_q <= dropped_n;
        end
    end
    always_comb begin
        state_n = (state == CLEAR && ptr == '1) ? READY : state;
        ptr_n   = (state == CLEAR && ptr != '1) ? ptr + 1'b1 : ptr;
    end
    // The sweep shares the single write port; user writes are only accepted once READY.
    always_comb begin
        clearing  = state == CLEAR;
        busy_n    = clearing && ptr != '1;
        dropped_n = clearing && bus.regwrite;
        mem_we    = !reset && (clearing || (bus.regwrite && bus.wa != '0));
        mem_wa    = clearing ? ptr : bus.wa;
        mem_wd    = clearing ? '0 : bus.wd;
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [REGBITS-1:0] a;
        assign a = bus.ra[i*REGBITS +: REGBITS];
`ifdef REGFILE_BYPASS_EN
        assign rd_p[i] = (clearing || a == '0) ? '0 : (bus.regwrite && a == bus.wa) ? bus.wd : mem[a];
`else
        assign rd_p[i] = (clearing || a == '0) ? '0 : mem[a];
`endif
    end
    always_comb begin
        bus.rd = '0;
        for (int i = 0; i < NREAD; i++) bus.rd[i*WIDTH +: WIDTH] = rd_p[i];
    end
    assign bus.busy       = busy_q;
    assign bus.wr_dropped = dropped_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp against an array model.
// Instance a uses the default geometry, instance b is 16 x 16-bit with four read ports.
`timescale 1ns/1ps
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(32), .REGBITS(3), .NREAD(2)) a_if ();
    regfile_mp_if #(.WIDTH(16), .REGBITS(4), .NREAD(4)) b_if ();
    regfile_mp #(.WIDTH(32), .REGBITS(3), .NREAD(2)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
    regfile_mp #(.WIDTH(16), .REGBITS(4), .NREAD(4)) dut_b (.clk(clk), .reset(reset_b), .bus(b_if));

    int tot = 0;
    int pass_cnt = 0;
    logic [31:0] ma [8];
    logic [15:0] mb [16];

    // Value a read port of instance a must show right now, given the model and the current write port.
    function automatic logic [31:0] exp_a(input logic [2:0] r);
        if (r == 3'd0) return 32'h0;
        if (BYP && a_if.regwrite && a_if.wa == r) return a_if.wd;
        return ma[r];
    endfunction

    function automatic logic [31:0] rd_a(input int p);
        return a_if.rd[p*32 +: 32];
    endfunction

    task automatic sweep_a(output int n, input int drop_at);
        n = 0;
        while (a_if.busy === 1'b1 && n < 64) begin
            a_if.regwrite = (n == drop_at);
            a_if.wa = 3'd3;
            a_if.wd = 32'hA5A5A5A5;
            a_if.ra = 6'($urandom);
            #1;
            tot++;
            if (a_if.rd !== '0) $display("FAIL sweep_rd: got %h expected 0", a_if.rd);
            else pass_cnt++;
            tot++;
            if (a_if.wr_dropped !== (drop_at >= 0 && n == drop_at + 1))
                $display("FAIL sweep_dropped n=%0d: got %b expected %b", n, a_if.wr_dropped, drop_at >= 0 && n == drop_at + 1);
            else pass_cnt++;
            n++;
            @(negedge clk);
        end
        a_if.regwrite = 1'b0;
        for (int k = 0; k < 8; k++) ma[k] = 32'h0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tot++;
        if (a_if.busy !== 1'b1 || a_if.wr_dropped !== 1'b0)
            $display("FAIL reset_flags: got busy=%b dropped=%b expected busy=1 dropped=0", a_if.busy, a_if.wr_dropped);
        else pass_cnt++;
        reset = 1'b0;
        sweep_a(n, -1);
        tot++;
        if (n != 7) $display("FAIL busy_len: got %0d expected 7", n);
        else pass_cnt++;
        for (int k = 1; k < 8; k++) begin
            a_if.ra = {3'(k), 3'(8 - k)};
            #1;
            for (int p = 0; p < 2; p++) begin
                tot++;
                if (rd_a(p) !== 32'h0) $display("FAIL reset_scan port%0d: got %h expected 0", p, rd_a(p));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_write();
        logic [2:0] r0, r1;
        for (int it = 0; it < 48; it++) begin
            @(negedge clk);
            a_if.regwrite = 1'($urandom);
            a_if.wa = 3'($urandom);
            a_if.wd = $urandom;
            r0 = $urandom_range(0, 1) ? a_if.wa : 3'($urandom);
            r1 = $urandom_range(0, 1) ? a_if.wa : 3'($urandom);
            if (it == 0) begin a_if.regwrite = 1'b1; a_if.wa = 3'd5; a_if.wd = 32'hDEADBEEF; r0 = 3'd0; r1 = 3'd0; end
            if (it == 1) begin a_if.regwrite = 1'b1; a_if.wa = 3'd0; a_if.wd = 32'h1234; r0 = 3'd5; r1 = 3'd0; end
            if (it == 2) begin a_if.regwrite = 1'b0; r0 = 3'd5; r1 = 3'd0; end
            a_if.ra = {r1, r0};
            #1;
            tot++;
            if (rd_a(0) !== exp_a(r0)) $display("FAIL write_rd0 it=%0d ra=%0d: got %h expected %h", it, r0, rd_a(0), exp_a(r0));
            else pass_cnt++;
            tot++;
            if (rd_a(1) !== exp_a(r1)) $display("FAIL write_rd1 it=%0d ra=%0d: got %h expected %h", it, r1, rd_a(1), exp_a(r1));
            else pass_cnt++;
            tot++;
            if (a_if.wr_dropped !== 1'b0) $display("FAIL write_dropped it=%0d: got %b expected 0", it, a_if.wr_dropped);
            else pass_cnt++;
            if (a_if.regwrite && a_if.wa != 3'd0) ma[a_if.wa] = a_if.wd;
        end
        @(negedge clk);
        a_if.regwrite = 1'b0;
    endtask

    task automatic test_drop();
        int n;
        @(negedge clk);
        reset = 1'b1;
        a_if.regwrite = 1'b1;
        a_if.wa = 3'd2;
        a_if.wd = 32'h55;
        @(negedge clk);
        reset = 1'b0;
        sweep_a(n, 1);
        tot++;
        if (n != 7) $display("FAIL drop_busy_len: got %0d expected 7", n);
        else pass_cnt++;
        for (int k = 1; k < 8; k++) begin
            a_if.ra = {3'(k), 3'd3};
            #1;
            tot++;
            if (rd_a(0) !== 32'h0) $display("FAIL drop_entry3: got %h expected 0", rd_a(0));
            else pass_cnt++;
            tot++;
            if (rd_a(1) !== 32'h0) $display("FAIL drop_scan entry%0d: got %h expected 0", k, rd_a(1));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            a_if.regwrite = 1'b1;
            a_if.wa = 3'(k);
            a_if.wd = 32'h11 * k;
            ma[k] = 32'h11 * k;
        end
        @(negedge clk);
        a_if.regwrite = 1'b0;
        for (int k = 1; k < 8; k++) begin
            a_if.ra = {3'(8 - k), 3'(k)};
            #1;
            for (int p = 0; p < 2; p++) begin
                tot++;
                if (rd_a(p) !== ma[p == 0 ? k : 8 - k]) $display("FAIL fill_scan port%0d: got %h expected %h", p, rd_a(p), ma[p == 0 ? k : 8 - k]);
                else pass_cnt++;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep_a(n, -1);
        tot++;
        if (n != 7) $display("FAIL mid_reset_busy_len: got %0d expected 7", n);
        else pass_cnt++;
        for (int k = 1; k < 8; k++) begin
            a_if.ra = {3'(k), 3'(8 - k)};
            #1;
            for (int p = 0; p < 2; p++) begin
                tot++;
                if (rd_a(p) !== 32'h0) $display("FAIL mid_reset_scan port%0d: got %h expected 0", p, rd_a(p));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        a_if.regwrite = 1'b1;
        a_if.wa = 3'd6;
        a_if.wd = 32'hCAFEF00D;
        a_if.ra = {3'd6, 3'd6};
        #1;
        for (int p = 0; p < 2; p++) begin
            tot++;
            if (rd_a(p) !== (BYP ? 32'hCAFEF00D : 32'h0)) $display("FAIL bypass_same port%0d: got %h expected %h", p, rd_a(p), BYP ? 32'hCAFEF00D : 32'h0);
            else pass_cnt++;
        end
        @(negedge clk);
        a_if.regwrite = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            tot++;
            if (rd_a(p) !== 32'hCAFEF00D) $display("FAIL bypass_next port%0d: got %h expected cafef00d", p, rd_a(p));
            else pass_cnt++;
        end
        ma[6] = 32'hCAFEF00D;
    endtask

    task automatic test_wide();
        int n;
        int base;
        logic [3:0] r;
        repeat (2) @(negedge clk);
        tot++;
        if (b_if.busy !== 1'b1) $display("FAIL wide_reset_busy: got %b expected 1", b_if.busy);
        else pass_cnt++;
        reset_b = 1'b0;
        n = 0;
        while (b_if.busy === 1'b1 && n < 64) begin
            b_if.ra = 16'($urandom);
            #1;
            tot++;
            if (b_if.rd !== '0) $display("FAIL wide_sweep_rd: got %h expected 0", b_if.rd);
            else pass_cnt++;
            n++;
            @(negedge clk);
        end
        tot++;
        if (n != 15) $display("FAIL wide_busy_len: got %0d expected 15", n);
        else pass_cnt++;
        mb[0] = 16'h0;
        for (int k = 1; k < 16; k++) begin
            b_if.regwrite = 1'b1;
            b_if.wa = 4'(k);
            b_if.wd = 16'h0100 + 16'(k);
            mb[k] = 16'h0100 + 16'(k);
            @(negedge clk);
        end
        b_if.regwrite = 1'b0;
        for (int it = 0; it < 8; it++) begin
            base = $urandom_range(0, 15);
            for (int p = 0; p < 4; p++) b_if.ra[p*4 +: 4] = 4'(base + p * 5);
            #1;
            for (int p = 0; p < 4; p++) begin
                r = 4'(base + p * 5);
                tot++;
                if (b_if.rd[p*16 +: 16] !== mb[r]) $display("FAIL wide_rd port%0d ra=%0d: got %h expected %h", p, r, b_if.rd[p*16 +: 16], mb[r]);
                else pass_cnt++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        a_if.regwrite = 1'b0;
        a_if.wa = '0;
        a_if.wd = '0;
        a_if.ra = '0;
        b_if.regwrite = 1'b0;
        b_if.wa = '0;
        b_if.wd = '0;
        b_if.ra = '0;
        test_reset();
        test_write();
        test_drop();
        test_reset_mid();
        test_bypass();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
